// File: rtl/cla_addsub_pkg.sv
// Shared constants, types and the lookahead propagate/generate combiner for cla_addsub_pipe.
package cla_addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Packed flag vector layout: {neg, zero, ovf, cout}
   localparam int unsigned FLG_COUT = 0;
   localparam int unsigned FLG_OVF  = 1;
   localparam int unsigned FLG_ZERO = 2;
   localparam int unsigned FLG_NEG  = 3;
   localparam int unsigned FLG_W    = 4;

   localparam int unsigned PG_MAX = 64;

   typedef logic [FLG_W-1:0] flags_t;

   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   // Combined P/G of the low n bit positions; n = 0 yields the identity (P=1, G=0).
   function automatic pg_t group_pg(input logic [PG_MAX-1:0] p,
                                    input logic [PG_MAX-1:0] g,
                                    input int unsigned       n);
      pg_t r;
      r.p = 1'b1;
      r.g = 1'b0;
      for (int unsigned i = 0; i < PG_MAX; i++) begin
         if (i < n) begin
            r.g = g[i] | (p[i] & r.g);
            r.p = r.p & p[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead group: per-bit carries from cin plus group propagate/generate.
module cla_group
   import cla_addsub_pkg::*;
#(
   parameter int unsigned GROUP = 4
) (
   input  logic [GROUP-1:0] p_i,
   input  logic [GROUP-1:0] g_i,
   input  logic             cin_i,
   output logic [GROUP-1:0] c_o,
   output logic             gp_o,
   output logic             gg_o
);

   pg_t pg_lo;
   pg_t pg_all;

   always_comb begin
      c_o   = '0;
      pg_lo = '0;
      for (int unsigned k = 0; k < GROUP; k++) begin
         pg_lo  = group_pg(PG_MAX'(p_i), PG_MAX'(g_i), k);
         c_o[k] = pg_lo.g | (pg_lo.p & cin_i);
      end
      pg_all = group_pg(PG_MAX'(p_i), PG_MAX'(g_i), GROUP);
      gp_o   = pg_all.p;
      gg_o   = pg_all.g;
   end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional signed saturation is enabled by defining CLA_ADDSUB_SATURATE_EN.
module cla_addsub_pipe
   import cla_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_neg
);

   localparam int unsigned NG = (GROUP < 1) ? 1 : WIDTH / GROUP;

   if (GROUP < 1 || GROUP > PG_MAX) begin : g_bad_group
      $fatal(1, "cla_addsub_pipe: GROUP must be in 1..%0d", PG_MAX);
   end else if (WIDTH % GROUP != 0 || NG > PG_MAX) begin : g_bad_width
      $fatal(1, "cla_addsub_pipe: WIDTH must be a multiple of GROUP");
   end

   logic             s1_valid_q, out_valid_q;
   logic             s1_load, s2_load;
   logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
   logic [NG:0]      c_d, c_q;
   logic             sat_q;
   logic [NG-1:0]    gp, gg, grp_p, grp_g;
   logic [WIDTH-1:0] b_eff, carry, sum_d, sum_q;
   flags_t           flags_d, flags_q;
   pg_t              pg, pg_c;
   logic             unused_grp;

   assign s2_load  = !out_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   // Stage 1: conditioning, group P/G, second-level lookahead to every group carry-in
   always_comb begin
      b_eff  = (in_sub == OP_SUB) ? ~in_b : in_b;
      p_d    = in_a ^ b_eff;
      g_d    = in_a & b_eff;
      gp     = '0;
      gg     = '0;
      pg     = '0;
      pg_c   = '0;
      for (int unsigned j = 0; j < NG; j++) begin
         pg    = group_pg(PG_MAX'(p_d[j*GROUP +: GROUP]), PG_MAX'(g_d[j*GROUP +: GROUP]), GROUP);
         gp[j] = pg.p;
         gg[j] = pg.g;
      end
      c_d    = '0;
      c_d[0] = in_cin ^ in_sub;
      for (int unsigned j = 1; j <= NG; j++) begin
         pg_c   = group_pg(PG_MAX'(gp), PG_MAX'(gg), j);
         c_d[j] = pg_c.g | (pg_c.p & c_d[0]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         p_q        <= '0;
         g_q        <= '0;
         c_q        <= '0;
         sat_q      <= 1'b0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            p_q   <= p_d;
            g_q   <= g_d;
            c_q   <= c_d;
            sat_q <= in_sat;
         end
      end
   end

   for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
         .p_i   (p_q[j*GROUP +: GROUP]),
         .g_i   (g_q[j*GROUP +: GROUP]),
         .cin_i (c_q[j]),
         .c_o   (carry[j*GROUP +: GROUP]),
         .gp_o  (grp_p[j]),
         .gg_o  (grp_g[j])
      );
   end

   // Stage 2: sum and flags. On overflow both MSB operands agree (p=0), so g's MSB is A's sign.
   always_comb begin
      flags_d           = '0;
      sum_d             = p_q ^ carry;
      flags_d[FLG_COUT] = c_q[NG];
      flags_d[FLG_OVF]  = carry[WIDTH-1] ^ c_q[NG];
`ifdef CLA_ADDSUB_SATURATE_EN
      if (sat_q && flags_d[FLG_OVF]) begin
         sum_d = g_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      flags_d[FLG_ZERO] = (sum_d == '0);
      flags_d[FLG_NEG]  = sum_d[WIDTH-1];
   end

`ifdef CLA_ADDSUB_SATURATE_EN
   assign unused_grp = ^{grp_p, grp_g};
`else
   assign unused_grp = ^{grp_p, grp_g, sat_q};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         flags_q     <= '0;
      end else if (s2_load) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sum_q   <= sum_d;
            flags_q <= flags_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_cout  = flags_q[FLG_COUT];
   assign out_ovf   = flags_q[FLG_OVF];
   assign out_zero  = flags_q[FLG_ZERO];
   assign out_neg   = flags_q[FLG_NEG];

endmodule
